// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: widths, opcodes, FSM states.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 6;
    localparam int unsigned OPW_DEF   = 3;

    localparam logic [OPW_DEF-1:0] OP_ADD = 3'b000;
    localparam logic [OPW_DEF-1:0] OP_SUB = 3'b001;
    localparam logic [OPW_DEF-1:0] OP_AND = 3'b010;
    localparam logic [OPW_DEF-1:0] OP_OR  = 3'b011;
    localparam logic [OPW_DEF-1:0] OP_XOR = 3'b100;
    localparam logic [OPW_DEF-1:0] OP_MUL = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MUL_STEP = 3'd2,
        ST_MUL_WB   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/alu_mul_stepper.sv
// Shift-and-add multiply state: accumulator, step index and sticky unsigned overflow.
// acc always mirrors the ALU_A operand the top drives during a multiply step.
module alu_mul_stepper
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] acc,
    output logic             sticky,
    output logic             last_c,
    output logic [WIDTH-1:0] next_b_c
);

    localparam int unsigned STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [STEP_W-1:0]  step;
    logic [STEP_W-1:0]  step_inc_c;
    logic [2*WIDTH-1:0] cur_shift_c;
    logic [2*WIDTH-1:0] next_shift_c;
    logic [WIDTH-1:0]   cur_b_c;
    logic [WIDTH:0]     sum_c;
    logic               step_ovf_c;

    // Partial product for this step and the next; high half of the shift is what falls off.
    always_comb begin
        step_inc_c   = step + STEP_W'(1);
        cur_shift_c  = {{WIDTH{1'b0}}, a} << step;
        next_shift_c = {{WIDTH{1'b0}}, a} << step_inc_c;
        last_c       = (step == STEP_W'(WIDTH - 1));
        cur_b_c      = b[step] ? cur_shift_c[WIDTH-1:0] : '0;
        next_b_c     = (!last_c && b[step_inc_c]) ? next_shift_c[WIDTH-1:0] : '0;
        sum_c        = {1'b0, acc} + {1'b0, cur_b_c};
        step_ovf_c   = (b[step] && (|cur_shift_c[2*WIDTH-1:WIDTH])) || sum_c[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            acc    <= '0;
            step   <= '0;
            sticky <= 1'b0;
        end else if (run) begin
            acc    <= alu_result;
            step   <= step_inc_c;
            sticky <= sticky | step_ovf_c;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for a shared combinational ALU: single-cycle ops plus shift-and-add MUL.
// Build option ALU_OP_SEQUENCER_SAT_EN saturates RESULT on an overflowing command.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [OPW-1:0]   CMD_OP,
    input  logic [WIDTH-1:0] CMD_A,
    input  logic [WIDTH-1:0] CMD_B,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [OPW-1:0]   ALU_OP,
    input  logic [WIDTH-1:0] ALU_RESULT,
    input  logic             ALU_OVF,
    output logic             RESULT_VALID,
    input  logic             RESULT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             OVERFLOW_FLAG,
    output logic             BUSY
);

    state_t           state_q;
    state_t           state_d;
    logic [OPW-1:0]   op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic             accept_c;
    logic             cmd_mul_c;
    logic             cmd_legal_c;
    logic             legal_c;
    logic             addsub_c;
    logic             exec_ovf_c;
    logic [WIDTH-1:0] exec_result_c;
    logic [WIDTH-1:0] mul_result_c;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_next_b_c;
    logic             mul_sticky;
    logic             mul_last_c;

`ifdef ALU_OP_SEQUENCER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Command decode and the value each completing path would write to RESULT.
    always_comb begin
        accept_c      = CMD_VALID && CMD_READY;
        cmd_mul_c     = (CMD_OP == OPW'(OP_MUL));
        cmd_legal_c   = (CMD_OP <= OPW'(OP_MUL));
        legal_c       = (op_r <= OPW'(OP_MUL));
        addsub_c      = (op_r == OPW'(OP_ADD)) || (op_r == OPW'(OP_SUB));
        exec_ovf_c    = addsub_c && ALU_OVF;
        exec_result_c = legal_c ? ALU_RESULT : '0;
        mul_result_c  = mul_acc;
`ifdef ALU_OP_SEQUENCER_SAT_EN
        if (exec_ovf_c) begin
            exec_result_c = a_r[WIDTH-1] ? SAT_NEG : SAT_POS;
        end
        if (mul_sticky) begin
            mul_result_c = '1;
        end
`endif
    end

    alu_mul_stepper #(.WIDTH(WIDTH)) u_mul_stepper (
        .clk        (CLK),
        .reset      (RESET),
        .start      (accept_c && cmd_mul_c),
        .run        (state_q == ST_MUL_STEP),
        .a          (a_r),
        .b          (b_r),
        .alu_result (ALU_RESULT),
        .acc        (mul_acc),
        .sticky     (mul_sticky),
        .last_c     (mul_last_c),
        .next_b_c   (mul_next_b_c)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept_c) state_d = cmd_mul_c ? ST_MUL_STEP : ST_EXEC;
            ST_EXEC:     state_d = ST_DONE;
            ST_MUL_STEP: if (mul_last_c) state_d = ST_MUL_WB;
            ST_MUL_WB:   state_d = ST_DONE;
            ST_DONE:     if (RESULT_READY) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // ALU operands are loaded one edge ahead so they are stable for the whole cycle that uses them.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CMD_READY     <= 1'b1;
            BUSY          <= 1'b0;
            RESULT_VALID  <= 1'b0;
            RESULT        <= '0;
            OVERFLOW_FLAG <= 1'b0;
            ALU_A         <= '0;
            ALU_B         <= '0;
            ALU_OP        <= '0;
            op_r          <= '0;
            a_r           <= '0;
            b_r           <= '0;
        end else begin
            CMD_READY    <= (state_d == ST_IDLE);
            BUSY         <= (state_d != ST_IDLE);
            RESULT_VALID <= (state_d == ST_DONE);
            ALU_A        <= '0;
            ALU_B        <= '0;
            ALU_OP       <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_r <= CMD_OP;
                        a_r  <= CMD_A;
                        b_r  <= CMD_B;
                        if (cmd_mul_c) begin
                            ALU_B <= CMD_B[0] ? CMD_A : '0;
                        end else if (cmd_legal_c) begin
                            ALU_A  <= CMD_A;
                            ALU_B  <= CMD_B;
                            ALU_OP <= CMD_OP;
                        end
                    end
                end
                ST_EXEC: begin
                    RESULT        <= exec_result_c;
                    OVERFLOW_FLAG <= exec_ovf_c;
                end
                ST_MUL_STEP: begin
                    if (!mul_last_c) begin
                        ALU_A <= ALU_RESULT;
                        ALU_B <= mul_next_b_c;
                    end
                end
                ST_MUL_WB: begin
                    RESULT        <= mul_result_c;
                    OVERFLOW_FLAG <= mul_sticky;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the external ALU.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int unsigned W = 6;
`ifdef ALU_OP_SEQUENCER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_ovf;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] result;
    logic         overflow_flag;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .CLK           (clk),
        .RESET         (reset),
        .CMD_VALID     (cmd_valid),
        .CMD_READY     (cmd_ready),
        .CMD_OP        (cmd_op),
        .CMD_A         (cmd_a),
        .CMD_B         (cmd_b),
        .ALU_A         (alu_a),
        .ALU_B         (alu_b),
        .ALU_OP        (alu_op),
        .ALU_RESULT    (alu_result),
        .ALU_OVF       (alu_ovf),
        .RESULT_VALID  (result_valid),
        .RESULT_READY  (result_ready),
        .RESULT        (result),
        .OVERFLOW_FLAG (overflow_flag),
        .BUSY          (busy)
    );

    // External combinational ALU with signed add/sub overflow.
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (alu_op)
            3'b000: begin
                alu_result = alu_a + alu_b;
                alu_ovf    = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'b001: begin
                alu_result = alu_a - alu_b;
                alu_ovf    = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Handshake one command; returns at the negedge of cycle 1 (handshake edge is cycle 0).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int lat, input logic [W-1:0] res,
                              input logic ovf);
        int cyc = 1;
        while (!result_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(lat));
        chk({name, "_result"}, 32'(result), 32'(res));
        chk({name, "_ovf"}, 32'(overflow_flag), 32'(ovf));
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         mul;
        logic         legal;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [2:0]   eop;

        reset        = 1'b1;
        cmd_valid    = 1'b0;
        result_ready = 1'b0;
        cmd_op       = '0;
        cmd_a        = '0;
        cmd_b        = '0;

        vecs[0]  = '{OP_ADD, 6'b011111, 6'b000001, SAT ? 6'b011111 : 6'b100000, 1'b1};
        vecs[1]  = '{OP_SUB, 6'b100000, 6'b000001, SAT ? 6'b100000 : 6'b011111, 1'b1};
        vecs[2]  = '{OP_SUB, 6'b000101, 6'b000011, 6'b000010, 1'b0};
        vecs[3]  = '{OP_AND, 6'b101100, 6'b100110, 6'b100100, 1'b0};
        vecs[4]  = '{OP_OR,  6'b101100, 6'b000011, 6'b101111, 1'b0};
        vecs[5]  = '{OP_XOR, 6'b111000, 6'b101010, 6'b010010, 1'b0};
        vecs[6]  = '{OP_MUL, 6'b000101, 6'b000110, 6'b011110, 1'b0};
        vecs[7]  = '{OP_MUL, 6'b001000, 6'b001000, SAT ? 6'b111111 : 6'b000000, 1'b1};
        vecs[8]  = '{OP_MUL, 6'b000111, 6'b001001, 6'b111111, 1'b0};
        vecs[9]  = '{OP_MUL, 6'b100001, 6'b000011, SAT ? 6'b111111 : 6'b100011, 1'b1};
        vecs[10] = '{OP_MUL, 6'b100000, 6'b000001, 6'b100000, 1'b0};
        vecs[11] = '{OP_MUL, 6'b011111, 6'b000011, SAT ? 6'b111111 : 6'b011101, 1'b1};
        vecs[12] = '{3'b111, 6'b010101, 6'b001100, 6'b000000, 1'b0};
        vecs[13] = '{3'b110, 6'b111111, 6'b111111, 6'b000000, 1'b0};
        vecs[14] = '{OP_ADD, 6'b100000, 6'b100000, SAT ? 6'b100000 : 6'b000000, 1'b1};
        vecs[15] = '{OP_ADD, 6'b000001, 6'b000001, 6'b000010, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {26'd0, result_valid, cmd_ready, busy, overflow_flag, 2'd0},
            {26'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_alu", {17'd0, alu_op, alu_a, alu_b}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {30'd0, cmd_ready, busy}, 32'b10);

        for (int i = 0; i < 16; i++) begin
            mul   = (vecs[i].op == OP_MUL);
            legal = (vecs[i].op <= OP_MUL);
            ea    = (legal && !mul) ? vecs[i].a : '0;
            eb    = mul ? (vecs[i].b[0] ? vecs[i].a : '0) : (legal ? vecs[i].b : '0);
            eop   = (legal && !mul) ? vecs[i].op : 3'b000;
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_alu_in", i), {14'd0, busy, alu_op, alu_a, alu_b, 2'd0},
                {14'd0, 1'b1, eop, ea, eb, 2'd0});
            wait_valid($sformatf("v%0d", i), mul ? int'(W + 2) : 2, vecs[i].res, vecs[i].ovf);
            release_result();
        end

        // Backpressure: result held, pending command refused until the consumer accepts.
        issue(OP_OR, 6'b000011, 6'b000100);
        wait_valid("bp", 2, 6'b000111, 1'b0);
        cmd_op    = OP_XOR;
        cmd_a     = 6'b110000;
        cmd_b     = 6'b000011;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k), {24'd0, result_valid, cmd_ready, result},
                {24'd0, 1'b1, 1'b0, 6'b000111});
        end
        release_result();
        chk("bp_idle", {30'd0, result_valid, cmd_ready}, 32'b01);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_accept", {30'd0, busy, cmd_ready}, 32'b10);
        wait_valid("bp2", 2, 6'b110011, 1'b0);
        release_result();

        // Reset during MUL step 3 discards the partial product.
        issue(OP_MUL, 6'b000101, 6'b000110);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_mul", {23'd0, result_valid, busy, cmd_ready, result},
            {23'd0, 1'b0, 1'b0, 1'b1, 6'b000000});
        repeat (10) @(negedge clk);
        chk("rst_no_result", 32'(result_valid), 32'd0);
        issue(OP_ADD, 6'b000001, 6'b000001);
        wait_valid("post_rst_add", 2, 6'b000010, 1'b0);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command front-end for the shared combinational ALU and its add/sub overflow detector.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode inputs.
- Registers RESULT and OVERFLOW_FLAG and holds them until the consumer accepts.
- Adds a multi-cycle unsigned MUL, sequenced as WIDTH shift-and-add steps through the ALU adder.

Parameters:
- WIDTH, 6: operand/result width.
- OPW, 3: opcode width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  OPW  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110/111 illegal.
- CMD_A  in  WIDTH  operand A.
- CMD_B  in  WIDTH  operand B.
- ALU_A  out  WIDTH  operand A driven to the ALU.
- ALU_B  out  WIDTH  operand B driven to the ALU.
- ALU_OP  out  OPW  opcode driven to the ALU.
- ALU_RESULT  in  WIDTH  combinational ALU result.
- ALU_OVF  in  1  ALU signed-overflow flag; meaningful only for ADD/SUB.
- RESULT_VALID  out  1  RESULT and OVERFLOW_FLAG are valid.
- RESULT_READY  in  1  consumer accepts the result.
- RESULT  out  WIDTH  registered result.
- OVERFLOW_FLAG  out  1  registered overflow for the completed command.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; RESULT=0; OVERFLOW_FLAG=0; RESULT_VALID=0; CMD_READY=1; BUSY=0; ALU_A=0; ALU_B=0; ALU_OP=000. RESET asserted mid-operation aborts the command and discards the partial result.
- States:
  - IDLE: CMD_READY=1. A handshake (CMD_VALID & CMD_READY) latches op, A and B. Go to EXEC for non-MUL ops, to MUL_STEP for MUL.
  - EXEC (1 cycle): drive ALU_A/ALU_B/ALU_OP from the latched values. Capture ALU_RESULT; capture OVERFLOW_FLAG = ALU_OVF for ADD/SUB, 0 otherwise. Go to DONE.
  - MUL_STEP (exactly WIDTH cycles, step i = 0..WIDTH-1): ALU_OP=000, ALU_A=acc, ALU_B=(A<<i) truncated to WIDTH when B[i]=1, otherwise 0.
    - acc <= ALU_RESULT.
    - Sticky overflow is set if B[i]=1 and any bit of A is shifted out, or if the 7-bit unsigned sum ALU_A+ALU_B (computed locally) has bit WIDTH set. ALU_OVF is ignored for MUL.
    - After step WIDTH-1: RESULT <= acc, go to DONE.
  - DONE: RESULT_VALID=1 and outputs held stable. Return to IDLE on RESULT_READY. A new command is not accepted in the same cycle.
- Illegal opcodes: EXEC path, ALU_OP forced to 000 with both operands 0. Result is 0, OVERFLOW_FLAG 0.
- Latency (handshake at cycle 0): RESULT_VALID is 1 from cycle 2 for single-cycle ops and from cycle WIDTH+2 (8 at the default) for MUL.
- ALU_* outputs are registered. Outside EXEC/MUL_STEP they hold 0/0/000.
- Arithmetic is modulo 2^WIDTH. ADD/SUB overflow is signed; MUL overflow is unsigned (true product > 2^WIDTH-1).

Optional Feature:
ALU_OP_SEQUENCER_SAT_EN
- Defined: on an overflowing command, RESULT saturates.
  - ADD/SUB: 011111 if A[WIDTH-1]=0, else 100000.
  - MUL: all ones.
  - OVERFLOW_FLAG is still set.
- Undefined: the wrapped result is returned. No extra logic is synthesized.

Decomposition:
- Shared package alu_pkg: opcode constants (OP_ADD..OP_MUL), the state enum type, and the WIDTH/OPW defaults.
- One natural sub-module, alu_mul_stepper: owns the acc/step counter/sticky-overflow registers and produces the ALU operands for each step. All handshaking stays in the top-level FSM.

Test Plan:
- ADD 011111 + 000001 -> RESULT 100000, OVERFLOW_FLAG 1 at cycle 2. With SAT_EN: RESULT 011111, flag 1.
- SUB 100000 - 000001 -> RESULT 011111, flag 1. SUB 000101 - 000011 -> 000010, flag 0.
- MUL 000101 x 000110 -> RESULT 011110, flag 0, RESULT_VALID at cycle 8. MUL 001000 x 001000 -> RESULT 000000, flag 1 (SAT_EN: 111111).
- Backpressure: hold RESULT_READY=0 for 5 cycles in DONE -> RESULT stable, CMD_READY=0, a pending CMD_VALID is not accepted. RESULT_READY=1 -> IDLE on the next cycle, then the command is accepted.
- RESET asserted at MUL step 3 -> next cycle IDLE, RESULT_VALID=0, RESULT=0. A following ADD 000001+000001 -> 000010.
- Illegal op 111 with A=010101 -> RESULT 000000, flag 0, RESULT_VALID at cycle 2.
